// File: rtl/stream_prefetch_buffer_pkg.sv
// Shared types and defaults for the stream prefetch buffer and its line store.
package stream_prefetch_buffer_pkg;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_CHECK = 2'd1,
    PF_WAIT  = 2'd2
  } pf_state_t;

  localparam int unsigned PF_DEPTH_DEF  = 4;
  localparam int unsigned PF_DEGREE_DEF = 2;
  localparam int unsigned PF_LINE_W_DEF = 256;
  localparam int unsigned PF_ADDR_W_DEF = 32;

  // Byte-offset width of a line of line_w bits.
  function automatic int unsigned line_offs(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/stream_prefetch_buffer_line_store.sv
// Fully-associative line store: lookup match/hit mux, duplicate probe,
// allocate, fill and consume-clear of DEPTH prefetched lines.
module pf_line_store
  import stream_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = PF_DEPTH_DEF,
  parameter int unsigned LINE_W = PF_LINE_W_DEF,
  parameter int unsigned LN_W   = PF_ADDR_W_DEF - line_offs(PF_LINE_W_DEF),
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LN_W-1:0]   lookup_line,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  input  logic              lookup_consume,
  input  logic [LN_W-1:0]   chk_line,
  output logic              chk_dup,
  input  logic              alloc_en,
  input  logic [PW-1:0]     alloc_idx,
  input  logic [LN_W-1:0]   alloc_line,
  input  logic              fill_en,
  input  logic [PW-1:0]     fill_idx,
  input  logic [LINE_W-1:0] fill_data
);

  typedef struct packed {
    logic [LN_W-1:0]   addr;
    logic [LINE_W-1:0] data;
    logic              available;
  } buffer_pkt_t;

  buffer_pkt_t      entry_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] match_s;
  logic [DEPTH-1:0] dup_s;
  logic [PW-1:0]    hit_idx_s;

  // Per-entry lookup match (filled entries only) and duplicate probe (any valid entry).
  always_comb begin
    match_s = '0;
    dup_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_r[i] && entry_r[i].available && (entry_r[i].addr == lookup_line);
      dup_s[i]   = valid_r[i] && (entry_r[i].addr == chk_line);
    end
  end

  // Lowest matching index wins.
  always_comb begin
    hit_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx_s = match_s[i] ? PW'(i) : hit_idx_s;
    end
  end

  assign lookup_hit  = |match_s;
  assign lookup_data = lookup_hit ? entry_r[hit_idx_s].data : {LINE_W{1'b0}};
  assign chk_dup     = |dup_s;

  // Entry storage; a same-edge allocation overrides a consume of the slot it replaces.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      if (lookup_consume && lookup_hit) begin
        valid_r[hit_idx_s] <= 1'b0;
      end
      if (alloc_en) begin
        valid_r[alloc_idx]           <= 1'b1;
        entry_r[alloc_idx].addr      <= alloc_line;
        entry_r[alloc_idx].available <= 1'b0;
      end
      if (fill_en) begin
        entry_r[fill_idx].data      <= fill_data;
        entry_r[fill_idx].available <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Sequential stream prefetcher: on each miss fetches the next DEGREE lines,
// one read in flight, with duplicate suppression and a one-deep pending trigger.
module stream_prefetch_buffer
  import stream_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = PF_DEPTH_DEF,
  parameter int unsigned DEGREE = PF_DEGREE_DEF,
  parameter int unsigned LINE_W = PF_LINE_W_DEF,
  parameter int unsigned ADDR_W = PF_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_valid,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  input  logic              lookup_consume,
  output logic              pf_read,
  output logic [ADDR_W-1:0] pf_addr,
  input  logic              pf_resp,
  input  logic [LINE_W-1:0] pf_rdata,
  output logic              busy
);

  localparam int unsigned OFFS = line_offs(LINE_W);
  localparam int unsigned LN_W = ADDR_W - OFFS;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEGREE + 1);
  localparam logic [CW-1:0] REM_FULL = CW'(DEGREE);
  localparam logic [CW-1:0] REM_ONE  = CW'(1);
  localparam logic [LN_W:0] LN_ONE   = (LN_W + 1)'(1);

  pf_state_t         state_r, state_nxt_s;
  logic [LN_W-1:0]   cur_r, cur_nxt_s;
  logic              wrap_r, wrap_nxt_s;
  logic [CW-1:0]     rem_r, rem_nxt_s;
  logic [PW-1:0]     wr_ptr_r;
  logic              pend_valid_r, pend_valid_nxt_s;
  logic [LN_W-1:0]   pend_line_r, pend_line_nxt_s;
  logic              take_pend_s;
  logic              pf_read_r, pf_read_nxt_s;
  logic [ADDR_W-1:0] pf_addr_r, pf_addr_nxt_s;
  logic              busy_r;
  logic              dup_s, alloc_en_s, fill_en_s;
  logic [LN_W:0]     cur_inc_s, trig_inc_s, pend_inc_s;
  logic              unused_s;

  // Carry out of the line increment marks a stream that ran off the address space.
  assign cur_inc_s  = {1'b0, cur_r} + LN_ONE;
  assign trig_inc_s = {1'b0, trig_addr[ADDR_W-1:OFFS]} + LN_ONE;
  assign pend_inc_s = {1'b0, pend_line_r} + LN_ONE;
  assign unused_s   = ^{trig_addr[OFFS-1:0], lookup_addr[OFFS-1:0]};

  pf_line_store #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .LN_W   (LN_W)
  ) u_store (
    .clk            (clk),
    .rst            (rst),
    .lookup_line    (lookup_addr[ADDR_W-1:OFFS]),
    .lookup_hit     (lookup_hit),
    .lookup_data    (lookup_data),
    .lookup_consume (lookup_consume),
    .chk_line       (cur_r),
    .chk_dup        (dup_s),
    .alloc_en       (alloc_en_s),
    .alloc_idx      (wr_ptr_r),
    .alloc_line     (cur_r),
    .fill_en        (fill_en_s),
    .fill_idx       (wr_ptr_r),
    .fill_data      (pf_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= PF_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and stream cursor; a held trigger preempts the current stream.
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    wrap_nxt_s  = wrap_r;
    rem_nxt_s   = rem_r;
    take_pend_s = 1'b0;
    case (state_r)
      PF_IDLE: begin
        if (trig_valid) begin
          {wrap_nxt_s, cur_nxt_s} = trig_inc_s;
          rem_nxt_s   = REM_FULL;
          take_pend_s = 1'b1;
          state_nxt_s = PF_CHECK;
        end else if (pend_valid_r) begin
          {wrap_nxt_s, cur_nxt_s} = pend_inc_s;
          rem_nxt_s   = REM_FULL;
          take_pend_s = 1'b1;
          state_nxt_s = PF_CHECK;
        end else begin
          state_nxt_s = PF_IDLE;
        end
      end
      PF_CHECK: begin
        if (pend_valid_r) begin
          {wrap_nxt_s, cur_nxt_s} = pend_inc_s;
          rem_nxt_s   = REM_FULL;
          take_pend_s = 1'b1;
          state_nxt_s = PF_CHECK;
        end else if (wrap_r) begin
          state_nxt_s = PF_IDLE;
        end else if (dup_s) begin
          {wrap_nxt_s, cur_nxt_s} = cur_inc_s;
          rem_nxt_s   = rem_r - REM_ONE;
          state_nxt_s = (rem_r == REM_ONE) ? PF_IDLE : PF_CHECK;
        end else begin
          state_nxt_s = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (!pf_resp) begin
          state_nxt_s = PF_WAIT;
        end else if (pend_valid_r) begin
          {wrap_nxt_s, cur_nxt_s} = pend_inc_s;
          rem_nxt_s   = REM_FULL;
          take_pend_s = 1'b1;
          state_nxt_s = PF_CHECK;
        end else begin
          {wrap_nxt_s, cur_nxt_s} = cur_inc_s;
          rem_nxt_s   = rem_r - REM_ONE;
          state_nxt_s = (rem_r == REM_ONE) ? PF_IDLE : PF_CHECK;
        end
      end
      default: begin
        state_nxt_s = PF_IDLE;
      end
    endcase
  end

  // Output decode: store strobes, next registered request and pending trigger.
  always_comb begin
    alloc_en_s = (state_r == PF_CHECK) && !pend_valid_r && !wrap_r && !dup_s;
    fill_en_s  = (state_r == PF_WAIT) && pf_resp;
    if (alloc_en_s) begin
      pf_read_nxt_s = 1'b1;
      pf_addr_nxt_s = {cur_r, {OFFS{1'b0}}};
    end else if (fill_en_s) begin
      pf_read_nxt_s = 1'b0;
      pf_addr_nxt_s = pf_addr_r;
    end else begin
      pf_read_nxt_s = pf_read_r;
      pf_addr_nxt_s = pf_addr_r;
    end
    if (trig_valid && (state_r != PF_IDLE)) begin
      pend_valid_nxt_s = 1'b1;
      pend_line_nxt_s  = trig_addr[ADDR_W-1:OFFS];
    end else if (take_pend_s) begin
      pend_valid_nxt_s = 1'b0;
      pend_line_nxt_s  = pend_line_r;
    end else begin
      pend_valid_nxt_s = pend_valid_r;
      pend_line_nxt_s  = pend_line_r;
    end
  end

  // Datapath, handshake and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_r        <= '0;
      wrap_r       <= 1'b0;
      rem_r        <= '0;
      wr_ptr_r     <= '0;
      pend_valid_r <= 1'b0;
      pend_line_r  <= '0;
      pf_read_r    <= 1'b0;
      pf_addr_r    <= '0;
      busy_r       <= 1'b0;
    end else begin
      cur_r        <= cur_nxt_s;
      wrap_r       <= wrap_nxt_s;
      rem_r        <= rem_nxt_s;
      wr_ptr_r     <= fill_en_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
      pend_valid_r <= pend_valid_nxt_s;
      pend_line_r  <= pend_line_nxt_s;
      pf_read_r    <= pf_read_nxt_s;
      pf_addr_r    <= pf_addr_nxt_s;
      busy_r       <= (state_nxt_s != PF_IDLE) || pend_valid_nxt_s;
    end
  end

  assign pf_read = pf_read_r;
  assign pf_addr = pf_addr_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Self-checking bench: directed stream scenarios, a lookup vector table and
// randomized triggers checked against a queue-based model of the line buffer.
module tb_stream_prefetch_buffer;

  localparam int DEPTH  = 4;
  localparam int DEGREE = 2;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [26:0] BASE_LINE = 27'h200_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              trig_valid;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              lookup_consume;
  logic              pf_read;
  logic [ADDR_W-1:0] pf_addr;
  logic              pf_resp;
  logic [LINE_W-1:0] pf_rdata;
  logic              busy;

  stream_prefetch_buffer #(.DEPTH(DEPTH), .DEGREE(DEGREE), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .trig_valid(trig_valid), .trig_addr(trig_addr),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .lookup_consume(lookup_consume), .pf_read(pf_read), .pf_addr(pf_addr),
    .pf_resp(pf_resp), .pf_rdata(pf_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    bit           consume;
    bit           hit;
    logic [255:0] data;
  } lk_vec_t;

  typedef struct {
    logic [26:0]  line;
    logic [255:0] data;
    bit           valid;
  } ment_t;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] exp_q[$];
  ment_t       mbuf[$];
  lk_vec_t     lk[6];

  function automatic logic [255:0] mem_data(input logic [31:0] a);
    return {4{a, ~a}} ^ {224'd0, 32'h0BAD_F00D};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig(input logic [31:0] a);
    trig_valid = 1'b1;
    trig_addr  = a;
    tick();
    trig_valid = 1'b0;
  endtask

  // Answer requests with the given latency until the block goes idle.
  task automatic serve(input int lat, input string tag);
    int          guard;
    bit          done;
    logic [31:0] a;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 300) begin
      guard++;
      if (pf_read) begin
        a = pf_addr;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL %s unexpected_req: got pf_addr %h expected no request", tag, a);
        end else begin
          chk({tag, " req_addr"}, a, exp_q.pop_front());
        end
        for (int j = 0; j < lat; j++) begin
          tick();
          chk({tag, " req_held"}, {pf_read, pf_addr}, {1'b1, a});
        end
        pf_resp  = 1'b1;
        pf_rdata = mem_data(a);
        tick();
        pf_resp  = 1'b0;
        pf_rdata = '0;
      end else if (!busy) begin
        done = 1'b1;
      end else begin
        tick();
      end
    end
    chk({tag, " idle_reached"}, done, 1'b1);
    chk({tag, " reqs_left"}, exp_q.size(), 0);
  endtask

  task automatic lookup_chk(input string tag, input logic [31:0] a, input bit cons,
                            input bit exp_hit, input logic [255:0] exp_data);
    lookup_addr    = a;
    lookup_consume = cons;
    #1;
    chk({tag, " hit"}, lookup_hit, exp_hit);
    chk({tag, " data"}, lookup_data, exp_data);
    tick();
    lookup_consume = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    int g;
    g = 0;
    while (!pf_read && g < 20) begin
      tick();
      g++;
    end
    chk({tag, " read_seen"}, pf_read, 1'b1);
  endtask

  // Reference model: FIFO of allocated lines, oldest dropped beyond DEPTH.
  function automatic bit m_has(input logic [26:0] ln);
    foreach (mbuf[i]) if (mbuf[i].valid && mbuf[i].line == ln) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void plan_stream(input logic [26:0] t);
    logic [27:0] ln;
    ment_t       e;
    for (int k = 1; k <= DEGREE; k++) begin
      ln = {1'b0, t} + 28'(k);
      if (ln[27]) break;
      if (!m_has(ln[26:0])) begin
        exp_q.push_back({ln[26:0], 5'd0});
        e.line  = ln[26:0];
        e.data  = mem_data({ln[26:0], 5'd0});
        e.valid = 1'b1;
        mbuf.push_back(e);
        if (mbuf.size() > DEPTH) void'(mbuf.pop_front());
      end
    end
  endfunction

  initial begin
    logic [26:0] t_line;
    logic [26:0] l_line;
    bit          e_hit;
    logic [255:0] e_data;
    bit          cons;

    rst = 1'b1; trig_valid = 1'b0; trig_addr = '0; lookup_addr = '0;
    lookup_consume = 1'b0; pf_resp = 1'b0; pf_rdata = '0;

    lk[0] = '{32'h1000_0064, 1'b0, 1'b1, mem_data(32'h1000_0060)};
    lk[1] = '{32'h1000_0060, 1'b1, 1'b1, mem_data(32'h1000_0060)};
    lk[2] = '{32'h1000_0060, 1'b0, 1'b0, 256'd0};
    lk[3] = '{32'h1000_0080, 1'b0, 1'b1, mem_data(32'h1000_0080)};
    lk[4] = '{32'h1000_009F, 1'b0, 1'b1, mem_data(32'h1000_0080)};
    lk[5] = '{32'h1000_0040, 1'b0, 1'b0, 256'd0};

    tick();
    tick();
    chk("rst pf_read", pf_read, 1'b0);
    chk("rst pf_addr", pf_addr, 32'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst hit", lookup_hit, 1'b0);
    chk("rst data", lookup_data, 256'd0);
    rst = 1'b0;
    tick();

    // Basic stream, 3-cycle memory latency.
    pulse_trig(32'h1000_0044);
    chk("trig busy", busy, 1'b1);
    chk("trig no_read_yet", pf_read, 1'b0);
    tick();
    chk("latency pf_read", pf_read, 1'b1);
    exp_q = '{32'h1000_0060, 32'h1000_0080};
    serve(3, "s1");

    for (int i = 0; i < 6; i++) begin
      lookup_chk($sformatf("lk%0d", i), lk[i].addr, lk[i].consume, lk[i].hit, lk[i].data);
    end

    // Resident 0x80 is skipped, only 0xA0 fetched.
    pulse_trig(32'h1000_0060);
    exp_q = '{32'h1000_00A0};
    serve(1, "s2");
    lookup_chk("lkA0", 32'h1000_00A0, 1'b0, 1'b1, mem_data(32'h1000_00A0));

    // Top of address space: one read, no wrap to zero.
    pulse_trig(32'hFFFF_FFC0);
    exp_q = '{32'hFFFF_FFE0};
    serve(0, "s3");
    lookup_chk("lk_top", 32'hFFFF_FFE0, 1'b0, 1'b1, mem_data(32'hFFFF_FFE0));
    lookup_chk("lk_zero", 32'h0000_0000, 1'b0, 1'b0, 256'd0);

    // Two triggers during WAIT: the newer one wins after the response.
    pulse_trig(32'h1000_0040);
    wait_read("s4");
    chk("s4 first_addr", pf_addr, 32'h1000_0060);
    trig_valid = 1'b1;
    trig_addr  = 32'h0000_2000;
    tick();
    trig_addr  = 32'h0000_3000;
    tick();
    trig_valid = 1'b0;
    chk("s4 not_aborted", {pf_read, pf_addr}, {1'b1, 32'h1000_0060});
    pf_resp  = 1'b1;
    pf_rdata = mem_data(32'h1000_0060);
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    exp_q = '{32'h0000_3020, 32'h0000_3040};
    serve(2, "s4");
    lookup_chk("lk3040", 32'h0000_3040, 1'b0, 1'b1, mem_data(32'h0000_3040));
    lookup_chk("lk80_evicted", 32'h1000_0080, 1'b0, 1'b0, 256'd0);
    lookup_chk("lk60_refetched", 32'h1000_0060, 1'b0, 1'b1, mem_data(32'h1000_0060));

    // Async reset in the middle of WAIT.
    pulse_trig(32'h0000_5000);
    wait_read("s5");
    #2;
    rst = 1'b1;
    #1;
    chk("arst pf_read", pf_read, 1'b0);
    chk("arst pf_addr", pf_addr, 32'd0);
    chk("arst busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    lookup_chk("arst lk5020", 32'h0000_5020, 1'b0, 1'b0, 256'd0);
    lookup_chk("arst lk3040", 32'h0000_3040, 1'b0, 1'b0, 256'd0);

    // Randomized triggers and lookups against the model.
    mbuf.delete();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) t_line = 27'h7FF_FFFF - 27'($urandom_range(0, 1));
      else t_line = BASE_LINE + 27'($urandom_range(0, 11));
      exp_q.delete();
      plan_stream(t_line);
      pulse_trig({t_line, 5'($urandom_range(0, 31))});
      serve($urandom_range(0, 3), $sformatf("rnd%0d", it));
      for (int q = 0; q < 3; q++) begin
        l_line = BASE_LINE + 27'($urandom_range(0, 13));
        cons   = 1'($urandom_range(0, 1));
        e_hit  = 1'b0;
        e_data = '0;
        foreach (mbuf[i]) begin
          if (mbuf[i].valid && mbuf[i].line == l_line) begin
            e_hit  = 1'b1;
            e_data = mbuf[i].data;
            if (cons) mbuf[i].valid = 1'b0;
          end
        end
        lookup_chk($sformatf("rnd%0d lk%0d", it, q), {l_line, 5'($urandom_range(0, 31))},
                   cons, e_hit, e_data);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
